filter_stream_arbiter: RTL and testbench
========================================

Name: filter_stream_arbiter

Overview:
- Shares one filter pipeline between two free-running camera pixel streams, A and B.
- Grants the filter to one source per whole frame and forwards that source's pixels and kernel select.
- Routes filter output pixels back to the correct source using a tag FIFO.
- Sits between the two camera front-ends and a filter whose kernel select is a runtime input.

Parameters:
- H_MAX, 239, last hcount of a line
- V_MAX, 319, last vcount of a frame
- TAG_DEPTH, 2, tag FIFO entries (power of 2)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-low reset
- a_valid_in, b_valid_in  input  1  source pixel valid
- a_pixel_in, b_pixel_in  input  16  RGB565 pixel
- a_hcount_in, b_hcount_in  input  8  source hcount
- a_vcount_in, b_vcount_in  input  9  source vcount
- a_kernel_in, b_kernel_in  input  3  requested kernel
- f_valid_out  output  1  pixel valid to filter
- f_pixel_out  output  16  pixel to filter
- f_hcount_out  output  8  hcount to filter
- f_vcount_out  output  9  vcount to filter
- f_kernel_out  output  3  kernel select to filter
- f_valid_in  input  1  filter output valid
- f_pixel_in  input  16  filter output pixel
- f_hcount_in  input  8  filter output hcount
- f_vcount_in  input  9  filter output vcount
- a_valid_out, b_valid_out  output  1  filtered pixel belongs to A / B
- pixel_data_out  output  16  filtered pixel
- hcount_out  output  8  filtered hcount
- vcount_out  output  9  filtered vcount
- owner_out  output  1  current feed owner (0=A, 1=B)
- busy_out  output  1  state is FEED

Behaviour:
- Reset (rst_in low at a clk edge):
  - All outputs 0 and state ARB.
  - Tag FIFO empty; last_served = B, so A wins the first tie.
- Frame start: valid with hcount=0 and vcount=0. Frame end: valid with hcount=H_MAX and vcount=V_MAX.
- FSM states are ARB and FEED.
  - ARB:
    - Grant goes to the source that presents a frame start this cycle.
    - If both present one, grant the source that is not last_served.
    - No grant while the tag FIFO is full.
    - On grant: latch that source's kernel into f_kernel_out, push its tag, set owner and last_served, forward the start pixel, go to FEED.
  - FEED:
    - Forward every owner pixel.
    - On the owner's frame end, forward the pixel and go to ARB in the next cycle.
    - A frame start cannot grant in the same cycle as a frame end.
- Non-owner pixels are always dropped; sources never stall.
- Owner frame start while in FEED (truncated frame):
  - Treat it as a frame end followed by a new grant to the same source.
  - The pixel is forwarded, the tag is pushed, and the state stays FEED.
  - If the tag FIFO is full, the pixel is dropped and the state goes to ARB.
- f_kernel_out changes only on a grant, never mid-frame.
- Feed path is a single register stage: 1 cycle from source to f_* outputs.
- Return path:
  - Single register stage: 1 cycle from f_* inputs to the outputs.
  - Head tag selects a_valid_out or b_valid_out.
  - Pop the head on a filter-output frame end.
  - Filter output with the FIFO empty: both valids 0, data passes through, no pop.
- Push and pop in the same cycle are both performed; occupancy is unchanged.

Optional Feature:
- Macro FILTER_ARB_STATS_EN.
- Defined:
  - Adds output ports a_frames_out / b_frames_out [15:0] counting granted frames.
  - Adds output ports a_drops_out / b_drops_out [15:0] counting frame starts that were dropped.
  - All four counters wrap and are cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package filter_arb_pkg holds:
  - typedef src_e {SRC_A, SRC_B}
  - typedef state_e {ARB, FEED}
  - the pixel_beat_t struct (pixel, hcount, vcount)
- Sub-module tag_fifo: synchronous, TAG_DEPTH entries of 1 bit, with push, pop, full and empty.

Test Plan:
- A sends a frame, B idle, kernels A=2 and B=5:
  - f_valid_out pulses 76800 times with f_kernel_out=2.
  - Filter output returns with a_valid_out only; the tag FIFO is empty afterwards.
- A and B assert frame start in the same cycle right after reset → A granted. At the next simultaneous start → B granted.
- B starts a frame mid-way through an A frame → all B pixels dropped and owner_out stays 0. With FILTER_ARB_STATS_EN, b_drops_out=1.
- Stub filter with 2-line latency, A and B alternating frames:
  - Every returned pixel is flagged to the correct source.
  - Pixels that overlap a tag switch are routed by tag.
- Hold the filter output so the tag FIFO fills, then present a frame start → no grant and state stays ARB until a pop.
- Pull rst_in low mid-FEED for 1 cycle → next cycle all outputs 0 and state ARB; the next A frame start is granted.

Source files
------------

// File: rtl/filter_arb_pkg.sv
// rtl/filter_arb_pkg.sv - shared types for filter_stream_arbiter and its tag FIFO
package filter_arb_pkg;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  typedef enum logic {ARB = 1'b0, FEED = 1'b1} state_e;

  typedef struct packed {
    logic [15:0] pixel;
    logic [7:0]  hcount;
    logic [8:0]  vcount;
  } pixel_beat_t;

  function automatic logic at_pos(input pixel_beat_t beat, input logic [7:0] h, input logic [8:0] v);
    return (beat.hcount == h) && (beat.vcount == v);
  endfunction

endpackage

// File: rtl/filter_stream_arbiter_tag_fifo.sv
// rtl/filter_stream_arbiter_tag_fifo.sv - 1-bit source-tag FIFO, one entry per granted frame
module tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic push_in,
  input  logic tag_in,
  input  logic pop_in,
  output logic head_out,
  output logic full_out,
  output logic empty_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_out  = (cnt_q == FULL_CNT);
  assign empty_out = (cnt_q == '0);
  assign head_out  = mem_q[rd_q];

  always_comb begin
    do_push = push_in && !full_out;
    do_pop  = pop_in && !empty_out;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = tag_in;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    // A simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/filter_stream_arbiter.sv
// rtl/filter_stream_arbiter.sv - frame-granular sharing of one filter between streams A and B
// Optional frame/drop counters are enabled with FILTER_ARB_STATS_EN.
module filter_stream_arbiter
  import filter_arb_pkg::*;
#(
  parameter int H_MAX     = 239,
  parameter int V_MAX     = 319,
  parameter int TAG_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        a_valid_in,
  input  logic        b_valid_in,
  input  logic [15:0] a_pixel_in,
  input  logic [15:0] b_pixel_in,
  input  logic [7:0]  a_hcount_in,
  input  logic [7:0]  b_hcount_in,
  input  logic [8:0]  a_vcount_in,
  input  logic [8:0]  b_vcount_in,
  input  logic [2:0]  a_kernel_in,
  input  logic [2:0]  b_kernel_in,
  output logic        f_valid_out,
  output logic [15:0] f_pixel_out,
  output logic [7:0]  f_hcount_out,
  output logic [8:0]  f_vcount_out,
  output logic [2:0]  f_kernel_out,
  input  logic        f_valid_in,
  input  logic [15:0] f_pixel_in,
  input  logic [7:0]  f_hcount_in,
  input  logic [8:0]  f_vcount_in,
  output logic        a_valid_out,
  output logic        b_valid_out,
  output logic [15:0] pixel_data_out,
  output logic [7:0]  hcount_out,
  output logic [8:0]  vcount_out,
  output logic        owner_out,
`ifdef FILTER_ARB_STATS_EN
  output logic [15:0] a_frames_out,
  output logic [15:0] b_frames_out,
  output logic [15:0] a_drops_out,
  output logic [15:0] b_drops_out,
`endif
  output logic        busy_out
);

  localparam logic [7:0] H_LAST = 8'(H_MAX);
  localparam logic [8:0] V_LAST = 9'(V_MAX);

  pixel_beat_t a_beat, b_beat, own_beat, ret_beat;
  logic        a_start, a_end, b_start, b_end;
  logic        own_is_b, own_valid, own_start, own_end;
  logic [2:0]  own_kernel;

  state_e      state_q, state_d;
  src_e        owner_q, owner_d, last_q, last_d, grant_src, push_tag;
  logic        f_valid_q, f_valid_d;
  pixel_beat_t f_beat_q, f_beat_d;
  logic [2:0]  f_kernel_q, f_kernel_d;
  logic        push, pop, ret_end;
  logic        fifo_head, fifo_full, fifo_empty;
  logic        r_a_q, r_a_d, r_b_q, r_b_d;
  pixel_beat_t r_beat_q, r_beat_d;

  assign a_beat   = {a_pixel_in, a_hcount_in, a_vcount_in};
  assign b_beat   = {b_pixel_in, b_hcount_in, b_vcount_in};
  assign ret_beat = {f_pixel_in, f_hcount_in, f_vcount_in};

  assign a_start = a_valid_in && at_pos(a_beat, 8'd0, 9'd0);
  assign a_end   = a_valid_in && at_pos(a_beat, H_LAST, V_LAST);
  assign b_start = b_valid_in && at_pos(b_beat, 8'd0, 9'd0);
  assign b_end   = b_valid_in && at_pos(b_beat, H_LAST, V_LAST);

  assign own_is_b   = (owner_q == SRC_B);
  assign own_valid  = own_is_b ? b_valid_in : a_valid_in;
  assign own_start  = own_is_b ? b_start : a_start;
  assign own_end    = own_is_b ? b_end : a_end;
  assign own_beat   = own_is_b ? b_beat : a_beat;
  assign own_kernel = own_is_b ? b_kernel_in : a_kernel_in;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    f_valid_d  = 1'b0;
    f_beat_d   = f_beat_q;
    f_kernel_d = f_kernel_q;
    push       = 1'b0;
    push_tag   = SRC_A;
    grant_src  = SRC_A;
    case (state_q)
      ARB: begin
        if (!fifo_full && (a_start || b_start)) begin
          if (a_start && b_start) begin
            grant_src = (last_q == SRC_A) ? SRC_B : SRC_A;
          end else begin
            grant_src = a_start ? SRC_A : SRC_B;
          end
          push       = 1'b1;
          push_tag   = grant_src;
          owner_d    = grant_src;
          last_d     = grant_src;
          f_kernel_d = (grant_src == SRC_B) ? b_kernel_in : a_kernel_in;
          f_valid_d  = 1'b1;
          f_beat_d   = (grant_src == SRC_B) ? b_beat : a_beat;
          state_d    = FEED;
        end
      end
      FEED: begin
        if (own_valid) begin
          // A restart by the owner closes the old frame and regrants it at once.
          if (own_start) begin
            if (!fifo_full) begin
              push       = 1'b1;
              push_tag   = owner_q;
              last_d     = owner_q;
              f_kernel_d = own_kernel;
              f_valid_d  = 1'b1;
              f_beat_d   = own_beat;
            end else begin
              state_d = ARB;
            end
          end else begin
            f_valid_d = 1'b1;
            f_beat_d  = own_beat;
            if (own_end) begin
              state_d = ARB;
            end
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    ret_end  = f_valid_in && at_pos(ret_beat, H_LAST, V_LAST);
    pop      = ret_end && !fifo_empty;
    r_beat_d = f_valid_in ? ret_beat : r_beat_q;
    r_a_d    = f_valid_in && !fifo_empty && !fifo_head;
    r_b_d    = f_valid_in && !fifo_empty && fifo_head;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= ARB;
      owner_q    <= SRC_A;
      last_q     <= SRC_B;
      f_valid_q  <= 1'b0;
      f_beat_q   <= '0;
      f_kernel_q <= '0;
      r_a_q      <= 1'b0;
      r_b_q      <= 1'b0;
      r_beat_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      f_valid_q  <= f_valid_d;
      f_beat_q   <= f_beat_d;
      f_kernel_q <= f_kernel_d;
      r_a_q      <= r_a_d;
      r_b_q      <= r_b_d;
      r_beat_q   <= r_beat_d;
    end
  end

  tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push_in  (push),
    .tag_in   (push_tag == SRC_B),
    .pop_in   (pop),
    .head_out (fifo_head),
    .full_out (fifo_full),
    .empty_out(fifo_empty)
  );

  assign f_valid_out    = f_valid_q;
  assign f_pixel_out    = f_beat_q.pixel;
  assign f_hcount_out   = f_beat_q.hcount;
  assign f_vcount_out   = f_beat_q.vcount;
  assign f_kernel_out   = f_kernel_q;
  assign a_valid_out    = r_a_q;
  assign b_valid_out    = r_b_q;
  assign pixel_data_out = r_beat_q.pixel;
  assign hcount_out     = r_beat_q.hcount;
  assign vcount_out     = r_beat_q.vcount;
  assign owner_out      = (owner_q == SRC_B);
  assign busy_out       = (state_q == FEED);

`ifdef FILTER_ARB_STATS_EN
  logic [15:0] a_frames_q, a_frames_d, b_frames_q, b_frames_d;
  logic [15:0] a_drops_q, a_drops_d, b_drops_q, b_drops_d;
  logic        grant_a, grant_b;

  // Every frame start that did not become a push was dropped.
  always_comb begin
    grant_a    = push && (push_tag == SRC_A);
    grant_b    = push && (push_tag == SRC_B);
    a_frames_d = a_frames_q + {15'd0, grant_a};
    b_frames_d = b_frames_q + {15'd0, grant_b};
    a_drops_d  = a_drops_q + {15'd0, a_start && !grant_a};
    b_drops_d  = b_drops_q + {15'd0, b_start && !grant_b};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      a_frames_q <= '0;
      b_frames_q <= '0;
      a_drops_q  <= '0;
      b_drops_q  <= '0;
    end else begin
      a_frames_q <= a_frames_d;
      b_frames_q <= b_frames_d;
      a_drops_q  <= a_drops_d;
      b_drops_q  <= b_drops_d;
    end
  end

  assign a_frames_out = a_frames_q;
  assign b_frames_out = b_frames_q;
  assign a_drops_out  = a_drops_q;
  assign b_drops_out  = b_drops_q;
`endif

endmodule

// File: tb/tb_filter_stream_arbiter.sv
// tb/tb_filter_stream_arbiter.sv - self-checking bench for filter_stream_arbiter
module tb_filter_stream_arbiter;

  localparam int TH    = 7;
  localparam int TV    = 3;
  localparam int DEPTH = 2;
  localparam int FPIX  = (TH + 1) * (TV + 1);
  localparam int LAT   = 2 * (TH + 1);

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        a_valid_in, b_valid_in;
  logic [15:0] a_pixel_in, b_pixel_in;
  logic [7:0]  a_hcount_in, b_hcount_in;
  logic [8:0]  a_vcount_in, b_vcount_in;
  logic [2:0]  a_kernel_in, b_kernel_in;
  logic        f_valid_out;
  logic [15:0] f_pixel_out;
  logic [7:0]  f_hcount_out;
  logic [8:0]  f_vcount_out;
  logic [2:0]  f_kernel_out;
  logic        f_valid_in;
  logic [15:0] f_pixel_in;
  logic [7:0]  f_hcount_in;
  logic [8:0]  f_vcount_in;
  logic        a_valid_out, b_valid_out;
  logic [15:0] pixel_data_out;
  logic [7:0]  hcount_out;
  logic [8:0]  vcount_out;
  logic        owner_out, busy_out;
`ifdef FILTER_ARB_STATS_EN
  logic [15:0] a_frames_out, b_frames_out, a_drops_out, b_drops_out;
`endif

  filter_stream_arbiter #(.H_MAX(TH), .V_MAX(TV), .TAG_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
    .a_pixel_in(a_pixel_in), .b_pixel_in(b_pixel_in),
    .a_hcount_in(a_hcount_in), .b_hcount_in(b_hcount_in),
    .a_vcount_in(a_vcount_in), .b_vcount_in(b_vcount_in),
    .a_kernel_in(a_kernel_in), .b_kernel_in(b_kernel_in),
    .f_valid_out(f_valid_out), .f_pixel_out(f_pixel_out),
    .f_hcount_out(f_hcount_out), .f_vcount_out(f_vcount_out),
    .f_kernel_out(f_kernel_out),
    .f_valid_in(f_valid_in), .f_pixel_in(f_pixel_in),
    .f_hcount_in(f_hcount_in), .f_vcount_in(f_vcount_in),
    .a_valid_out(a_valid_out), .b_valid_out(b_valid_out),
    .pixel_data_out(pixel_data_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .owner_out(owner_out),
`ifdef FILTER_ARB_STATS_EN
    .a_frames_out(a_frames_out), .b_frames_out(b_frames_out),
    .a_drops_out(a_drops_out), .b_drops_out(b_drops_out),
`endif
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frame ownership tracked as flags, tags as a queue.
  bit          m_busy;
  int          m_owner, m_last, e_kern;
  bit          e_fv, e_ra, e_rb, e_rupd;
  logic [15:0] e_fp, e_rp;
  logic [7:0]  e_fh, e_rh;
  logic [8:0]  e_fvc, e_rvc;
  bit          tagq[$];
  int          m_afr, m_bfr, m_adr, m_bdr;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 1; e_kern = 0;
    e_fv = 0; e_ra = 0; e_rb = 0; e_rupd = 0;
    tagq.delete();
    m_afr = 0; m_bfr = 0; m_adr = 0; m_bdr = 0;
  endtask

  task automatic take(input int s);
    e_fp  = (s == 0) ? a_pixel_in : b_pixel_in;
    e_fh  = (s == 0) ? a_hcount_in : b_hcount_in;
    e_fvc = (s == 0) ? a_vcount_in : b_vcount_in;
  endtask

  task automatic model_edge();
    bit as, ae, bs, be, ov, os, oe, hd;
    int sz, g;
    if (!rst_in) begin
      model_reset();
      return;
    end
    as = a_valid_in && a_hcount_in == 0 && a_vcount_in == 0;
    ae = a_valid_in && a_hcount_in == TH && a_vcount_in == TV;
    bs = b_valid_in && b_hcount_in == 0 && b_vcount_in == 0;
    be = b_valid_in && b_hcount_in == TH && b_vcount_in == TV;
    sz = tagq.size();
    hd = (sz > 0) ? tagq[0] : 1'b0;
    g = -1;
    e_fv = 0;
    if (!m_busy) begin
      if (sz < DEPTH) begin
        if (as && bs) g = 1 - m_last;
        else if (as) g = 0;
        else if (bs) g = 1;
      end
    end else begin
      ov = (m_owner == 0) ? a_valid_in : b_valid_in;
      os = (m_owner == 0) ? as : bs;
      oe = (m_owner == 0) ? ae : be;
      if (ov && os) begin
        if (sz < DEPTH) g = m_owner;
        else m_busy = 0;
      end else if (ov) begin
        e_fv = 1;
        take(m_owner);
        if (oe) m_busy = 0;
      end
    end
    if (g >= 0) begin
      e_fv = 1; take(g);
      m_busy = 1; m_owner = g; m_last = g;
      e_kern = (g == 0) ? int'(a_kernel_in) : int'(b_kernel_in);
    end
    if (as && g != 0) m_adr++;
    if (bs && g != 1) m_bdr++;
    if (g == 0) m_afr++;
    if (g == 1) m_bfr++;
    e_rupd = f_valid_in; e_ra = 0; e_rb = 0;
    if (f_valid_in) begin
      e_rp = f_pixel_in; e_rh = f_hcount_in; e_rvc = f_vcount_in;
      e_ra = (sz > 0) && !hd;
      e_rb = (sz > 0) && hd;
      if (sz > 0 && f_hcount_in == TH && f_vcount_in == TV) void'(tagq.pop_front());
    end
    if (g >= 0) tagq.push_back(g == 1);
  endtask

  task automatic check_model();
    chk("m_f_valid", f_valid_out, e_fv);
    chk("m_f_kernel", f_kernel_out, e_kern);
    chk("m_owner", owner_out, m_owner);
    chk("m_busy", busy_out, m_busy);
    chk("m_a_valid", a_valid_out, e_ra);
    chk("m_b_valid", b_valid_out, e_rb);
    if (e_fv) begin
      chk("m_f_pixel", f_pixel_out, e_fp);
      chk("m_f_hcount", f_hcount_out, e_fh);
      chk("m_f_vcount", f_vcount_out, e_fvc);
    end
    if (e_rupd) begin
      chk("m_ret_pixel", pixel_data_out, e_rp);
      chk("m_ret_hcount", hcount_out, e_rh);
      chk("m_ret_vcount", vcount_out, e_rvc);
    end
`ifdef FILTER_ARB_STATS_EN
    chk("m_a_frames", a_frames_out, m_afr & 16'hFFFF);
    chk("m_b_frames", b_frames_out, m_bfr & 16'hFFFF);
    chk("m_a_drops", a_drops_out, m_adr & 16'hFFFF);
    chk("m_b_drops", b_drops_out, m_bdr & 16'hFFFF);
`endif
  endtask

  // Filter stub: replays the feed outputs after a fixed delay.
  typedef struct packed {logic v; logic [15:0] p; logic [7:0] h; logic [8:0] vc;} stub_t;
  stub_t stub_q[$];
  bit    stub_on;

  task automatic stub_advance();
    stub_t sb;
    if (stub_on) begin
      stub_q.push_back({f_valid_out, f_pixel_out, f_hcount_out, f_vcount_out});
      if (stub_q.size() > LAT) begin
        sb = stub_q.pop_front();
        f_valid_in = sb.v; f_pixel_in = sb.p; f_hcount_in = sb.h; f_vcount_in = sb.vc;
      end else begin
        f_valid_in = 1'b0;
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    check_model();
    stub_advance();
    @(negedge clk_in);
  endtask

  task automatic drive_src(input int s, input bit v, input int h, input int vc, input int k);
    logic [15:0] p;
    p = 16'($urandom);
    if (s == 0) begin
      a_valid_in = v; a_pixel_in = p; a_hcount_in = 8'(h); a_vcount_in = 9'(vc); a_kernel_in = 3'(k);
    end else begin
      b_valid_in = v; b_pixel_in = p; b_hcount_in = 8'(h); b_vcount_in = 9'(vc); b_kernel_in = 3'(k);
    end
  endtask

  task automatic drive_ret(input bit v, input int h, input int vc);
    f_valid_in = v; f_pixel_in = 16'($urandom); f_hcount_in = 8'(h); f_vcount_in = 9'(vc);
  endtask

  task automatic do_reset();
    stub_on = 0;
    stub_q.delete();
    drive_src(0, 0, 0, 0, 0);
    drive_src(1, 0, 0, 0, 0);
    drive_ret(0, 0, 0);
    rst_in = 1'b0;
    step();
    step();
    rst_in = 1'b1;
  endtask

  typedef struct {
    bit av; int ah; int avc; int ak;
    bit bv; int bh; int bvc; int bk;
    bit fv; int fh; int fvc;
    bit e_fv; bit e_own; bit e_busy; int e_k; bit e_ra; bit e_rb;
  } vec_t;
  vec_t tbl[14];

  int act[2], gh[2], gv[2];

  task automatic gen_src(input int s);
    if (act[s] != 0) begin
      if ($urandom_range(0, 63) == 0) begin
        gh[s] = 0; gv[s] = 0;
      end
      if ($urandom_range(0, 7) != 0) begin
        drive_src(s, 1, gh[s], gv[s], $urandom_range(0, 7));
        if (gh[s] == TH && gv[s] == TV) act[s] = 0;
        else if (gh[s] == TH) begin gh[s] = 0; gv[s]++; end
        else gh[s]++;
      end else begin
        drive_src(s, 0, 0, 0, $urandom_range(0, 7));
      end
    end else if ($urandom_range(0, 15) == 0) begin
      act[s] = 1;
      drive_src(s, 1, 0, 0, $urandom_range(0, 7));
      gh[s] = 1; gv[s] = 0;
    end else begin
      drive_src(s, 0, 0, 0, $urandom_range(0, 7));
    end
  endtask

  int n_fv, n_k2, n_ra, n_rb, n_own1;

  initial begin
    tbl[0]  = '{1, 0, 0, 2,   1, 0, 0, 5,   0, 0, 0,    1, 0, 1, 2, 0, 0};
    tbl[1]  = '{1, 1, 0, 2,   1, 1, 0, 5,   0, 0, 0,    1, 0, 1, 2, 0, 0};
    tbl[2]  = '{1, 0, 0, 3,   0, 0, 0, 5,   0, 0, 0,    1, 0, 1, 3, 0, 0};
    tbl[3]  = '{0, 0, 0, 2,   1, 0, 0, 5,   0, 0, 0,    0, 0, 1, 3, 0, 0};
    tbl[4]  = '{1, 0, 0, 2,   0, 0, 0, 5,   0, 0, 0,    0, 0, 0, 3, 0, 0};
    tbl[5]  = '{0, 0, 0, 2,   1, 0, 0, 5,   0, 0, 0,    0, 0, 0, 3, 0, 0};
    tbl[6]  = '{0, 0, 0, 2,   0, 0, 0, 5,   1, TH, TV,  0, 0, 0, 3, 1, 0};
    tbl[7]  = '{0, 0, 0, 2,   1, 0, 0, 5,   0, 0, 0,    1, 1, 1, 5, 0, 0};
    tbl[8]  = '{0, 0, 0, 2,   1, TH, TV, 5, 1, TH, TV,  1, 1, 0, 5, 1, 0};
    tbl[9]  = '{1, 0, 0, 2,   1, 0, 0, 5,   0, 0, 0,    1, 0, 1, 2, 0, 0};
    tbl[10] = '{1, 0, 0, 2,   1, 0, 0, 5,   0, 0, 0,    0, 0, 0, 2, 0, 0};
    tbl[11] = '{0, 0, 0, 2,   0, 0, 0, 5,   1, TH, TV,  0, 0, 0, 2, 0, 1};
    tbl[12] = '{1, 0, 0, 2,   1, 0, 0, 5,   0, 0, 0,    1, 1, 1, 5, 0, 0};
    tbl[13] = '{0, 0, 0, 2,   0, 0, 0, 5,   1, TH, TV,  0, 1, 1, 5, 1, 0};

    model_reset();
    rst_in = 1'b0;
    @(negedge clk_in);
    do_reset();
    chk("rst_f_valid", f_valid_out, 0);
    chk("rst_f_pixel", f_pixel_out, 0);
    chk("rst_f_hcount", f_hcount_out, 0);
    chk("rst_f_vcount", f_vcount_out, 0);
    chk("rst_f_kernel", f_kernel_out, 0);
    chk("rst_a_valid", a_valid_out, 0);
    chk("rst_b_valid", b_valid_out, 0);
    chk("rst_pixel_data", pixel_data_out, 0);
    chk("rst_owner", owner_out, 0);
    chk("rst_busy", busy_out, 0);

    // Filter output while no tag is queued.
    drive_ret(1, TH, TV);
    f_pixel_in = 16'hBEEF;
    step();
    chk("empty_ret_a_valid", a_valid_out, 0);
    chk("empty_ret_b_valid", b_valid_out, 0);
    chk("empty_ret_pixel", pixel_data_out, 16'hBEEF);
    drive_ret(0, 0, 0);
    drive_src(0, 1, 0, 0, 1);
    step();
    chk("empty_ret_then_grant", busy_out, 1);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive_src(0, tbl[i].av, tbl[i].ah, tbl[i].avc, tbl[i].ak);
      drive_src(1, tbl[i].bv, tbl[i].bh, tbl[i].bvc, tbl[i].bk);
      drive_ret(tbl[i].fv, tbl[i].fh, tbl[i].fvc);
      step();
      chk($sformatf("tbl%0d_f_valid", i), f_valid_out, tbl[i].e_fv);
      chk($sformatf("tbl%0d_owner", i), owner_out, tbl[i].e_own);
      chk($sformatf("tbl%0d_busy", i), busy_out, tbl[i].e_busy);
      chk($sformatf("tbl%0d_f_kernel", i), f_kernel_out, tbl[i].e_k);
      chk($sformatf("tbl%0d_a_valid", i), a_valid_out, tbl[i].e_ra);
      chk($sformatf("tbl%0d_b_valid", i), b_valid_out, tbl[i].e_rb);
    end

    // One A frame through a 2-line-latency filter, B idle.
    do_reset();
    stub_on = 1;
    n_fv = 0; n_k2 = 0; n_ra = 0; n_rb = 0;
    for (int i = 0; i < FPIX + LAT + 8; i++) begin
      if (i < FPIX) drive_src(0, 1, i % (TH + 1), i / (TH + 1), 2);
      else drive_src(0, 0, 0, 0, 2);
      drive_src(1, 0, 0, 0, 5);
      step();
      if (f_valid_out) begin
        n_fv++;
        if (f_kernel_out == 3'd2) n_k2++;
      end
      if (a_valid_out) n_ra++;
      if (b_valid_out) n_rb++;
    end
    chk("aframe_f_valid_pulses", n_fv, FPIX);
    chk("aframe_kernel2_pulses", n_k2, FPIX);
    chk("aframe_a_returns", n_ra, FPIX);
    chk("aframe_b_returns", n_rb, 0);
    stub_on = 0;
    stub_q.delete();
    drive_ret(1, TH, TV);
    step();
    chk("aframe_fifo_empty_a", a_valid_out, 0);
    chk("aframe_fifo_empty_b", b_valid_out, 0);
    drive_ret(0, 0, 0);

    // B starts mid-way through an A frame.
    do_reset();
    n_fv = 0; n_own1 = 0;
    for (int i = 0; i < FPIX + 10; i++) begin
      if (i < FPIX) drive_src(0, 1, i % (TH + 1), i / (TH + 1), 2);
      else drive_src(0, 0, 0, 0, 2);
      if (i >= 10) drive_src(1, 1, (i - 10) % (TH + 1), (i - 10) / (TH + 1), 5);
      else drive_src(1, 0, 0, 0, 5);
      step();
      if (f_valid_out) n_fv++;
      if (owner_out) n_own1++;
    end
    chk("bmid_owner_b_cycles", n_own1, 0);
    chk("bmid_f_valid_pulses", n_fv, FPIX);
    chk("bmid_busy_after", busy_out, 0);
`ifdef FILTER_ARB_STATS_EN
    chk("bmid_b_drops", b_drops_out, 1);
    chk("bmid_a_frames", a_frames_out, 1);
`endif

    // Reset pulled mid-FEED.
    do_reset();
    drive_src(1, 0, 0, 0, 5);
    for (int i = 0; i < 5; i++) begin
      drive_src(0, 1, i, 0, 4);
      step();
    end
    chk("midrst_busy_before", busy_out, 1);
    drive_src(0, 1, 5, 0, 4);
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    chk("midrst_f_valid", f_valid_out, 0);
    chk("midrst_f_kernel", f_kernel_out, 0);
    chk("midrst_f_pixel", f_pixel_out, 0);
    chk("midrst_owner", owner_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_a_valid", a_valid_out, 0);
    drive_src(0, 1, 6, 0, 4);
    step();
    chk("midrst_no_midframe_grant", busy_out, 0);
    drive_src(0, 1, 0, 0, 4);
    step();
    chk("midrst_regrant_busy", busy_out, 1);
    chk("midrst_regrant_f_valid", f_valid_out, 1);
    chk("midrst_regrant_kernel", f_kernel_out, 4);

    // Random alternating traffic through the stub filter.
    do_reset();
    stub_on = 1;
    act[0] = 0; act[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      gen_src(0);
      gen_src(1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
